// File: rtl/rect_sum_eval_pkg.sv
// Shared definitions for the rectangle-sum evaluator: FSM encoding, corner
// indices and the integral-image address helper used by the compute stage too.
package rect_sum_eval_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_COMBINE,
        ST_OUTPUT
    } state_t;

    localparam logic [1:0] CORNER_D = 2'd0;
    localparam logic [1:0] CORNER_B = 2'd1;
    localparam logic [1:0] CORNER_C = 2'd2;
    localparam logic [1:0] CORNER_A = 2'd3;

    // Row-major integral address; callers truncate to their address width.
    function automatic logic [31:0] calc_addr(input logic [31:0] x,
                                              input logic [31:0] y,
                                              input logic [31:0] img_w);
        return y * img_w + x;
    endfunction

endpackage

// File: rtl/rect_sum_eval_corner_gen.sv
// Corner enable mask and per-corner (x,y) for a latched rectangle query.
// Corners touching row -1 or column -1 are masked off.
module rect_corner_gen
    import rect_sum_eval_pkg::*;
#(
    parameter int COORD_W = 2
) (
    input  logic [COORD_W-1:0]            x0,
    input  logic [COORD_W-1:0]            y0,
    input  logic [COORD_W-1:0]            x1,
    input  logic [COORD_W-1:0]            y1,
    output logic [3:0]                    mask,
    output logic [3:0][COORD_W-1:0]       cx,
    output logic [3:0][COORD_W-1:0]       cy
);

    logic               has_top;
    logic               has_left;
    logic [COORD_W-1:0] xm1;
    logic [COORD_W-1:0] ym1;

    always_comb begin
        has_top  = (y0 != '0);
        has_left = (x0 != '0);
        xm1      = x0 - COORD_W'(1);
        ym1      = y0 - COORD_W'(1);

        mask           = '0;
        mask[CORNER_D] = 1'b1;
        mask[CORNER_B] = has_top;
        mask[CORNER_C] = has_left;
        mask[CORNER_A] = has_top & has_left;

        cx = '0;
        cy = '0;
        cx[CORNER_D] = x1;   cy[CORNER_D] = y1;
        cx[CORNER_B] = x1;   cy[CORNER_B] = ym1;
        cx[CORNER_C] = xm1;  cy[CORNER_C] = y1;
        cx[CORNER_A] = xm1;  cy[CORNER_A] = ym1;
    end

endmodule

// File: rtl/rect_sum_eval.sv
// Rectangle-sum evaluator: reads up to four integral-image corners serially
// from the M10K and returns D - B - C + A, or an error for a malformed query.
module rect_sum_eval
    import rect_sum_eval_pkg::*;
#(
    parameter int IMG_W   = 4,
    parameter int IMG_H   = 4,
    parameter int COORD_W = 2,
    parameter int ADDR_W  = 8,
    parameter int INT_W   = 8,
    parameter int SUM_W   = INT_W + 2,
    parameter int RD_LAT  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COORD_W-1:0]       in_x0,
    input  logic [COORD_W-1:0]       in_y0,
    input  logic [COORD_W-1:0]       in_x1,
    input  logic [COORD_W-1:0]       in_y1,
    output logic [ADDR_W-1:0]        M10K_read_address_int_wire,
    input  logic [INT_W-1:0]         M10K_read_data_int,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [SUM_W-1:0]  out_sum,
    output logic                     out_err
);

    localparam logic [31:0] IMG_W_U = IMG_W;
    localparam logic [31:0] IMG_H_U = IMG_H;
    localparam int          WAIT_N  = (RD_LAT > 1) ? RD_LAT - 1 : 1;
    localparam int          CNT_W   = $clog2(WAIT_N + 1);

    state_t                    state;
    logic [1:0]                cur;
    logic [CNT_W-1:0]          wcnt;
    logic [COORD_W-1:0]        qx0, qy0, qx1, qy1;
    logic signed [SUM_W-1:0]   acc;

    logic [3:0]                mask;
    logic [3:0][COORD_W-1:0]   cx;
    logic [3:0][COORD_W-1:0]   cy;

    logic                      bad_query;
    logic [31:0]               addr_full;
    logic signed [SUM_W-1:0]   data_ext;
    logic                      next_found;
    logic [1:0]                next_idx;

    rect_corner_gen #(.COORD_W(COORD_W)) u_corner_gen (
        .x0   (qx0),
        .y0   (qy0),
        .x1   (qx1),
        .y1   (qy1),
        .mask (mask),
        .cx   (cx),
        .cy   (cy)
    );

    assign in_ready  = (state == ST_IDLE);
    assign addr_full = calc_addr(32'(cx[cur]), 32'(cy[cur]), IMG_W_U);
    assign data_ext  = {{(SUM_W-INT_W){M10K_read_data_int[INT_W-1]}}, M10K_read_data_int};

    always_comb begin
        bad_query = (in_x0 > in_x1) || (in_y0 > in_y1) ||
                    (32'(in_x1) >= IMG_W_U) || (32'(in_y1) >= IMG_H_U);
    end

    // First enabled corner after the current one, in D, B, C, A order.
    always_comb begin
        next_found = 1'b0;
        next_idx   = cur;
        for (int k = 0; k < 4; k++) begin
            if (!next_found && (k > int'(cur)) && mask[k]) begin
                next_found = 1'b1;
                next_idx   = 2'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                      <= ST_IDLE;
            cur                        <= CORNER_D;
            wcnt                       <= '0;
            qx0                        <= '0;
            qy0                        <= '0;
            qx1                        <= '0;
            qy1                        <= '0;
            acc                        <= '0;
            M10K_read_address_int_wire <= '0;
            out_valid                  <= 1'b0;
            out_sum                    <= '0;
            out_err                    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        qx0 <= in_x0;
                        qy0 <= in_y0;
                        qx1 <= in_x1;
                        qy1 <= in_y1;
                        acc <= '0;
                        cur <= CORNER_D;
                        if (bad_query) begin
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
                            out_sum   <= '0;
                            state     <= ST_OUTPUT;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    M10K_read_address_int_wire <= addr_full[ADDR_W-1:0];
                    if (RD_LAT > 1) begin
                        wcnt  <= CNT_W'(WAIT_N - 1);
                        state <= ST_WAIT;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_WAIT: begin
                    if (wcnt == '0) state <= ST_CAPTURE;
                    else            wcnt  <= wcnt - CNT_W'(1);
                end
                ST_CAPTURE: begin
                    // D and A add, B and C subtract.
                    if (cur == CORNER_D || cur == CORNER_A) acc <= acc + data_ext;
                    else                                    acc <= acc - data_ext;
                    if (next_found) begin
                        cur   <= next_idx;
                        state <= ST_ISSUE;
                    end else begin
                        state <= ST_COMBINE;
                    end
                end
                ST_COMBINE: begin
                    out_sum   <= acc;
                    out_err   <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_sum_eval.sv
// Directed bench for rect_sum_eval on a 4x4 all-ones image (I(x,y)=(x+1)(y+1)).
module tb_rect_sum_eval;

    localparam int IMG_W = 4, IMG_H = 4, COORD_W = 2, ADDR_W = 8, INT_W = 8;
    localparam int SUM_W = INT_W + 2, RD_LAT = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [COORD_W-1:0]      in_x0, in_y0, in_x1, in_y1;
    logic [ADDR_W-1:0]       rd_addr;
    logic [INT_W-1:0]        rd_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [SUM_W-1:0] out_sum;
    logic                    out_err;

    int total = 0;
    int bad   = 0;

    logic [INT_W-1:0] mem [256];
    logic [INT_W-1:0] rd_q;

    always #5 clk = ~clk;

    // Address registered by DUT at edge t; data visible for sampling at t+RD_LAT.
    always @(posedge clk) rd_q <= mem[rd_addr];
    assign rd_data = rd_q;

    rect_sum_eval #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .COORD_W(COORD_W), .ADDR_W(ADDR_W),
        .INT_W(INT_W), .SUM_W(SUM_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .in_valid                   (in_valid),
        .in_ready                   (in_ready),
        .in_x0                      (in_x0),
        .in_y0                      (in_y0),
        .in_x1                      (in_x1),
        .in_y1                      (in_y1),
        .M10K_read_address_int_wire (rd_addr),
        .M10K_read_data_int         (rd_data),
        .out_valid                  (out_valid),
        .out_ready                  (out_ready),
        .out_sum                    (out_sum),
        .out_err                    (out_err)
    );

    task automatic accept(input int x0, input int y0, input int x1, input int y1);
        @(negedge clk);
        in_x0 = 2'(x0); in_y0 = 2'(y0); in_x1 = 2'(x1); in_y1 = 2'(y1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Accepts a query and steps edge by edge to the expected result cycle.
    task automatic do_query(input string name, input int x0, input int y0,
                            input int x1, input int y1, input int n,
                            input int a0, input int a1, input int a2, input int a3,
                            input int exp_sum);
        int exp_a[4];
        int last;
        exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2; exp_a[3] = a3;
        last = n * (RD_LAT + 1) + 1;
        accept(x0, y0, x1, y1);
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL %s busy_ready: got %0b want 0", name, in_ready);
        end
        for (int i = 1; i <= last; i++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < n; k++) begin
                if (i == 1 + k * (RD_LAT + 1)) begin
                    total++;
                    if (int'(rd_addr) !== exp_a[k]) begin
                        bad++;
                        $display("FAIL %s addr%0d at E0+%0d: got %0d want %0d",
                                 name, k, i, rd_addr, exp_a[k]);
                    end
                end
            end
            if (i < last) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++; $display("FAIL %s early_valid at E0+%0d: got %0b want 0", name, i, out_valid);
                end
            end
        end
        total++;
        if (out_valid !== 1'b1 || out_err !== 1'b0 || int'(out_sum) !== exp_sum) begin
            bad++;
            $display("FAIL %s result at E0+%0d: got v=%0b e=%0b s=%0d want v=1 e=0 s=%0d",
                     name, last, out_valid, out_err, out_sum, exp_sum);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s handshake: got v=%0b rdy=%0b want v=0 rdy=1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 ||
            out_err !== 1'b0 || rd_addr !== '0) begin
            bad++;
            $display("FAIL reset_values: got rdy=%0b v=%0b s=%0d e=%0b a=%0d want 1 0 0 0 0",
                     in_ready, out_valid, out_sum, out_err, rd_addr);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_full_rect();
        do_query("full_rect", 1, 1, 2, 2, 4, 10, 2, 8, 0, 4);
    endtask

    task automatic test_single_corner();
        do_query("single_corner", 0, 0, 3, 3, 1, 15, 0, 0, 0, 16);
    endtask

    task automatic test_skip_cols();
        do_query("left_edge", 0, 2, 3, 3, 2, 15, 7, 0, 0, 8);
    endtask

    task automatic test_skip_rows();
        do_query("top_edge", 2, 0, 2, 3, 2, 14, 13, 0, 0, 4);
    endtask

    task automatic test_async_reset();
        logic [ADDR_W-1:0] a_prev;
        accept(1, 1, 2, 2);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
        end
        a_prev = rd_addr;
        total++;
        if (a_prev !== 8'd2) begin
            bad++; $display("FAIL async_pre addrB: got %0d want 2", a_prev);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 ||
            out_err !== 1'b0 || rd_addr !== '0) begin
            bad++;
            $display("FAIL async_reset: got rdy=%0b v=%0b s=%0d e=%0b a=%0d want 1 0 0 0 0",
                     in_ready, out_valid, out_sum, out_err, rd_addr);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_query("after_reset", 1, 1, 2, 2, 4, 10, 2, 8, 0, 4);
    endtask

    task automatic test_invalid_hold();
        logic [ADDR_W-1:0] a_prev;
        a_prev = rd_addr;
        accept(2, 1, 1, 3);
        total++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_sum !== '0 || rd_addr !== a_prev) begin
            bad++;
            $display("FAIL invalid_result: got v=%0b e=%0b s=%0d a=%0d want 1 1 0 %0d",
                     out_valid, out_err, out_sum, rd_addr, a_prev);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || out_err !== 1'b1 || out_sum !== '0 ||
                in_ready !== 1'b0 || rd_addr !== a_prev) begin
                bad++;
                $display("FAIL invalid_hold cyc%0d: got v=%0b e=%0b s=%0d rdy=%0b a=%0d want 1 1 0 0 %0d",
                         i, out_valid, out_err, out_sum, in_ready, rd_addr, a_prev);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL invalid_release: got v=%0b rdy=%0b want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = '0;
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++)
                mem[y * IMG_W + x] = 8'((x + 1) * (y + 1));
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_x0 = '0; in_y0 = '0; in_x1 = '0; in_y1 = '0;

        test_reset();
        test_full_rect();
        test_single_corner();
        test_skip_cols();
        test_skip_rows();
        test_async_reset();
        test_invalid_hold();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
